// File: rtl/sdram_ctrl_pkg.sv
// sdram_ctrl_pkg
//   State codes for the SDRAM init and work FSMs. The data path and the
//   command decoder (sdram_cmd) import these same codes, so the numeric
//   values are part of the interface and must not be renumbered.
//   Also holds the dwell-counter width and a helper that turns a
//   "last count value" into a counter compare constant.
package sdram_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [3:0] {
    I_NOP  = 4'd0,
    I_PRE  = 4'd1,
    I_TRP  = 4'd2,
    I_AR   = 4'd3,
    I_TRF  = 4'd4,
    I_MRS  = 4'd5,
    I_TRSC = 4'd6,
    I_DONE = 4'd7
  } init_state_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_TRP    = 4'd9,
    W_AR     = 4'd10,
    W_TRFC   = 4'd11
  } work_state_t;

  // A state that must last N+1 cycles exits when cnt_clk == N. Negative N
  // (timing parameter smaller than the state's fixed overhead) collapses
  // to a single-cycle dwell instead of wrapping to a huge compare value.
  function automatic logic [CNT_W-1:0] dwell_end(input int n);
    return (n < 0) ? '0 : CNT_W'(n);
  endfunction

endpackage

// File: rtl/sdram_ctrl.sv
// sdram_ctrl
//   Control FSM for the SDRAM interface. Runs the power-up init sequence
//   (wait, precharge-all, INIT_AR_NUM auto-refreshes, mode-register set),
//   then arbitrates periodic auto-refresh, burst write and burst read.
//   Bursts use auto-precharge, so normal operation has no PRECHARGE state;
//   W_TRP only covers the precharge time after a burst.
//
// Ports
//   clk_100m         system clock
//   rst_n            asynchronous active-low reset
//   sdram_wr_req     burst write request (level, held until ack)
//   sdram_rd_req     burst read request (level, held until ack)
//   sdram_wr_ack     high during W_WRITE/W_WD (BURST_LEN cycles)
//   sdram_rd_ack     registered W_RD, aligned to the data path's read register
//   sdram_init_done  high while init FSM is in I_DONE
//   sdram_busy       high whenever work FSM is not idle
//   init_state       init FSM state code
//   work_state       work FSM state code
//   cnt_clk          cycles spent in the current state (saturating)
module sdram_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int T_POWERUP   = 20000,
  parameter int T_RP        = 2,
  parameter int T_RFC       = 7,
  parameter int T_MRD       = 2,
  parameter int T_RCD       = 2,
  parameter int T_WR        = 2,
  parameter int CAS_LAT     = 3,
  parameter int BURST_LEN   = 8,
  parameter int REF_PERIOD  = 780,
  parameter int INIT_AR_NUM = 8
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             sdram_wr_req,
  input  logic             sdram_rd_req,
  output logic             sdram_wr_ack,
  output logic             sdram_rd_ack,
  output logic             sdram_init_done,
  output logic             sdram_busy,
  output logic [3:0]       init_state,
  output logic [3:0]       work_state,
  output logic [CNT_W-1:0] cnt_clk
);

  // Exit compare values: "exit at cnt_clk = N" means N+1 cycles in state.
  localparam logic [CNT_W-1:0] PWR_END  = dwell_end(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] ITRP_END = dwell_end(T_RP - 2);
  localparam logic [CNT_W-1:0] ITRF_END = dwell_end(T_RFC - 2);
  localparam logic [CNT_W-1:0] MRD_END  = dwell_end(T_MRD - 2);
  localparam logic [CNT_W-1:0] RCD_END  = dwell_end(T_RCD - 2);
  localparam logic [CNT_W-1:0] WD_END   = dwell_end(BURST_LEN - 2);
  localparam logic [CNT_W-1:0] TWR_END  = dwell_end(T_WR - 1);
  localparam logic [CNT_W-1:0] WTRP_END = dwell_end(T_RP - 1);
  localparam logic [CNT_W-1:0] CL_END   = dwell_end(CAS_LAT - 2);
  localparam logic [CNT_W-1:0] RD_END   = dwell_end(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] WRFC_END = dwell_end(T_RFC - 2);

  localparam int AR_W  = (INIT_AR_NUM > 0) ? $clog2(INIT_AR_NUM + 1) : 1;
  localparam int REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [AR_W-1:0]  AR_LAST = AR_W'(INIT_AR_NUM);
  localparam logic [REF_W-1:0] REF_END = REF_W'(REF_PERIOD - 1);

  init_state_t      init_q, init_d;
  work_state_t      work_q, work_d;
  logic [CNT_W-1:0] cnt_q;
  logic [AR_W-1:0]  ar_cnt_q;
  logic [REF_W-1:0] ref_cnt_q;
  logic             ref_pend_q;
  logic             is_wr_q;
  logic             rd_ack_q;
  logic             init_done;
  logic             state_chg;
  logic             ref_expire;
  logic             ar_take;

  assign init_done  = (init_q == I_DONE);
  assign state_chg  = (init_d != init_q) || (work_d != work_q);
  assign ref_expire = init_done && (ref_cnt_q == REF_END);
  assign ar_take    = (work_q == W_IDLE) && (work_d == W_AR);

  // ---------------------------------------------------------------------
  // Init FSM
  // ---------------------------------------------------------------------
  always_comb begin
    init_d = init_q;
    unique case (init_q)
      I_NOP:   if (cnt_q == PWR_END)  init_d = I_PRE;
      I_PRE:                          init_d = I_TRP;
      I_TRP:   if (cnt_q == ITRP_END) init_d = I_AR;
      I_AR:                           init_d = I_TRF;
      // ar_cnt_q already counts the I_AR just left, so compare to the total.
      I_TRF:   if (cnt_q == ITRF_END) init_d = (ar_cnt_q == AR_LAST) ? I_MRS : I_AR;
      I_MRS:                          init_d = I_TRSC;
      I_TRSC:  if (cnt_q == MRD_END)  init_d = I_DONE;
      default:                        init_d = I_DONE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Work FSM
  // ---------------------------------------------------------------------
  always_comb begin
    work_d = work_q;
    unique case (work_q)
      W_IDLE: begin
        if (init_done) begin
          if (ref_pend_q)                        work_d = W_AR;
          else if (sdram_wr_req || sdram_rd_req) work_d = W_ACTIVE;
        end
      end
      W_ACTIVE:                         work_d = W_TRCD;
      // Direction was latched when leaving idle, so a request dropped
      // after that point cannot redirect or abort the burst.
      W_TRCD:   if (cnt_q == RCD_END)   work_d = is_wr_q ? W_WRITE : W_READ;
      W_WRITE:                          work_d = W_WD;
      W_WD:     if (cnt_q == WD_END)    work_d = W_TWR;
      W_TWR:    if (cnt_q == TWR_END)   work_d = W_TRP;
      W_READ:                           work_d = W_CL;
      W_CL:     if (cnt_q == CL_END)    work_d = W_RD;
      W_RD:     if (cnt_q == RD_END)    work_d = W_TRP;
      W_TRP:    if (cnt_q == WTRP_END)  work_d = W_IDLE;
      W_AR:                             work_d = W_TRFC;
      W_TRFC:   if (cnt_q == WRFC_END)  work_d = W_IDLE;
      default:                          work_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, dwell counter, init AR counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      init_q   <= I_NOP;
      work_q   <= W_IDLE;
      cnt_q    <= '0;
      ar_cnt_q <= '0;
      is_wr_q  <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      init_q <= init_d;
      work_q <= work_d;
      if (state_chg)       cnt_q <= '0;
      else if (~&cnt_q)    cnt_q <= cnt_q + 1'b1;
      if (init_q == I_AR)  ar_cnt_q <= ar_cnt_q + 1'b1;
      // Write wins over read when both are held at arbitration time.
      if ((work_q == W_IDLE) && (work_d == W_ACTIVE)) is_wr_q <= sdram_wr_req;
      rd_ack_q <= (work_q == W_RD);
    end
  end

  // ---------------------------------------------------------------------
  // Refresh timer: free-running once init is done. A single pending flag
  // absorbs expiries that land while one is already waiting. If an expiry
  // coincides with taking the previous refresh, the new one wins so it is
  // not lost.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      if (init_done) begin
        if (ref_cnt_q == REF_END) ref_cnt_q <= '0;
        else                      ref_cnt_q <= ref_cnt_q + 1'b1;
      end
      if (ref_expire)   ref_pend_q <= 1'b1;
      else if (ar_take) ref_pend_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign init_state      = init_q;
  assign work_state      = work_q;
  assign cnt_clk         = cnt_q;
  assign sdram_init_done = init_done;
  assign sdram_busy      = (work_q != W_IDLE);
  assign sdram_wr_ack    = (work_q == W_WRITE) || (work_q == W_WD);
  assign sdram_rd_ack    = rd_ack_q;

endmodule
